// File: rtl/ctr_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package ctr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_IMM     = 5'b00100;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;

endpackage

// File: rtl/ctr_decode.sv
// Combinational classifier for the instruction register: addi / bne / illegal,
// plus the matching 12-bit immediate field.
module ctr_decode
  import ctr_pkg::*;
#(
  parameter int IN_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0] ir,
  output logic                is_addi,
  output logic                is_bne,
  output logic                illegal,
  output logic [11:0]         imm
);

  logic unused_ir_bits;

  always_comb begin
    is_addi = (ir[6:2] == OP_IMM);
    is_bne  = (ir[6:2] == OP_BRANCH) && (ir[14:12] == FUNCT3_BNE);
    illegal = !(is_addi || is_bne);
    // B-type immediate drops bit 0; the datapath re-appends it.
    if (is_bne) imm = {ir[31], ir[7], ir[30:25], ir[11:8]};
    else        imm = ir[31:20];
  end

  assign unused_ir_bits = ^{ir[19:15], ir[1:0]};

endmodule

// File: rtl/mc_ctr_unit.sv
// Multi-cycle control FSM for the RV32I datapath (addi, bne).
// Optional performance counters are built when CTR_PERF_CNT_EN is defined.
module mc_ctr_unit
  import ctr_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic [IN_WIDTH-1:0]  instr,
  input  logic                 eq,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [2:0]           ALUctrl,
  output logic                 ALUsrc,
  output logic [11:0]          ImmSrc,
  output logic                 PCsrc,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | imem_req high until imem_ready, IR loaded on accept
  // DECODE | classify IR
  // EXEC   | ALU op; bne updates PC here and retires
  // WB     | addi register write and PC+4, retires
  // HALT   | illegal opcode seen, only reset leaves

  state_t              state;
  logic [IN_WIDTH-1:0] ir;
  logic                halted_q;
  logic                is_addi;
  logic                is_bne;
  logic                illegal;
  logic [11:0]         imm;

  ctr_decode #(.IN_WIDTH(IN_WIDTH)) u_decode (
    .ir      (ir),
    .is_addi (is_addi),
    .is_bne  (is_bne),
    .illegal (illegal),
    .imm     (imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_FETCH;
        S_FETCH:  if (imem_ready) begin
                    ir    <= instr;
                    state <= S_DECODE;
                  end
        S_DECODE: if (illegal) begin
                    state    <= S_HALT;
                    halted_q <= 1'b1;
                  end else begin
                    state <= S_EXEC;
                  end
        S_EXEC:   state <= is_bne ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset
  // removes them in the same instant it clears the state.
  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    ALUctrl  = 3'b000;
    ALUsrc   = 1'b0;
    ImmSrc   = 12'h000;
    PCsrc    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      S_EXEC: begin
        ImmSrc = imm;
        if (is_bne) begin
          ALUctrl = ALU_SUB;
          PCWrite = 1'b1;
          PCsrc   = ~eq;
        end else begin
          ALUctrl = ALU_ADD;
          ALUsrc  = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        ALUctrl  = ALU_ADD;
        ALUsrc   = 1'b1;
        ImmSrc   = imm;
      end
      default: ;
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = halted_q;

`ifdef CTR_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] retired_q;
  logic [CNT_WIDTH-1:0] cycle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (busy) cycle_q <= cycle_q + CNT_WIDTH'(1);
      if ((state == S_EXEC && is_bne) || state == S_WB)
        retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`else
  assign retired_cnt = '0;
  assign cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_mc_ctr_unit.sv
// Scoreboard bench for mc_ctr_unit: stimulus queues expected control records,
// a negedge monitor pops one whenever the DUT drives any control output.
module tb_mc_ctr_unit;

  typedef struct packed {
    logic [31:0] cyc;
    logic        irw;
    logic        pcw;
    logic        rw;
    logic [2:0]  alu;
    logic        alusrc;
    logic [11:0] imm;
    logic        pcsrc;
  } rec_t;

`ifdef CTR_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ready = 1'b0;
  logic        eq = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        imem_req, IRWrite, PCWrite, RegWrite, ALUsrc, PCsrc, busy, halted;
  logic [2:0]  ALUctrl;
  logic [11:0] ImmSrc;
  logic [31:0] retired_cnt, cycle_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  rec_t q[$];

  mc_ctr_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req),
    .imem_ready(imem_ready), .instr(instr), .eq(eq), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
    .ImmSrc(ImmSrc), .PCsrc(PCsrc), .busy(busy), .halted(halted),
    .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic irw, input logic pcw, input logic rw, input logic [2:0] alu,
                      input logic alusrc, input logic [11:0] imm, input logic pcsrc);
    rec_t r;
    r = '{cyc: cyc, irw: irw, pcw: pcw, rw: rw, alu: alu, alusrc: alusrc, imm: imm, pcsrc: pcsrc};
    q.push_back(r);
  endtask

  // Monitor: any control activity must match the next queued expectation.
  always @(negedge clk) begin
    rec_t got, exp;
    if (rst_n && (IRWrite || PCWrite || RegWrite || ALUsrc || PCsrc ||
                  ALUctrl != 3'b000 || ImmSrc != 12'h000)) begin
      got = '{cyc: cyc, irw: IRWrite, pcw: PCWrite, rw: RegWrite, alu: ALUctrl,
              alusrc: ALUsrc, imm: ImmSrc, pcsrc: PCsrc};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ctrl: got cyc=%0d irw=%b pcw=%b rw=%b alu=%b src=%b imm=%h pcsrc=%b, none expected",
                 got.cyc, got.irw, got.pcw, got.rw, got.alu, got.alusrc, got.imm, got.pcsrc);
      end else begin
        exp = q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL ctrl_record: got cyc=%0d irw=%b pcw=%b rw=%b alu=%b src=%b imm=%h pcsrc=%b expected cyc=%0d irw=%b pcw=%b rw=%b alu=%b src=%b imm=%h pcsrc=%b",
                   got.cyc, got.irw, got.pcw, got.rw, got.alu, got.alusrc, got.imm, got.pcsrc,
                   exp.cyc, exp.irw, exp.pcw, exp.rw, exp.alu, exp.alusrc, exp.imm, exp.pcsrc);
        end
      end
    end
  end

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("imem_req_after_start", imem_req, 1);
  endtask

  // Entered and left in FETCH, just after a rising edge.
  task automatic run(input logic [31:0] w, input int waits, input logic e,
                     input logic bne, input logic [11:0] imm);
    instr = w;
    imem_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("imem_req_wait", imem_req, 1);
      step();
    end
    check("imem_req_accept", imem_req, 1);
    imem_ready = 1'b1;
    push(1, 0, 0, 3'b000, 0, 12'h000, 0);
    step();
    imem_ready = 1'b0;
    check("busy_decode", busy, 1);
    step();
    eq = e;
    if (bne) push(0, 1, 0, 3'b001, 0, imm, ~e);
    else     push(0, 0, 0, 3'b000, 1, imm, 0);
    step();
    if (!bne) begin
      push(0, 1, 1, 3'b000, 1, imm, 0);
      step();
    end
    check("imem_req_refetch", imem_req, 1);
  endtask

  initial begin
    #2;
    check("rst_imem_req", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_strobes", {IRWrite, PCWrite, RegWrite, PCsrc, ALUsrc}, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_cycle", cycle_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    go();

    run(32'h00500093, 0, 1'b0, 1'b0, 12'h005);   // addi x1,x0,5
    run(32'hFE009EE3, 0, 1'b0, 1'b1, 12'hFFE);   // bne, not equal -> taken
    run(32'hFE009EE3, 0, 1'b1, 1'b1, 12'hFFE);   // bne, equal -> PC+4
    run(32'h00A00113, 3, 1'b0, 1'b0, 12'h00A);   // addi x2,x0,10 with 3 wait cycles
    check("retired_seq1", retired_cnt, PERF ? 32'd4 : 32'd0);
    check("cycle_seq1", cycle_cnt, PERF ? 32'd17 : 32'd0);

    // R-type word: fetch completes, then DECODE traps into HALT
    instr = 32'h00000033;
    imem_ready = 1'b1;
    push(1, 0, 0, 3'b000, 0, 12'h000, 0);
    step();
    imem_ready = 1'b0;
    step();
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_imem_req", imem_req, 0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("halt_ignores_start", {halted, busy, imem_req}, 3'b100);
    check("halt_retired_hold", retired_cnt, PERF ? 32'd4 : 32'd0);
    check("halt_cycle_hold", cycle_cnt, PERF ? 32'd19 : 32'd0);
    rst_n = 1'b0;
    #1;
    check("halt_reset_halted", halted, 0);
    check("halt_reset_cycle", cycle_cnt, 0);
    step();
    rst_n = 1'b1;
    go();

    run(32'h00500093, 0, 1'b0, 1'b0, 12'h005);
    run(32'h00A00113, 0, 1'b0, 1'b0, 12'h00A);
    run(32'hFE009EE3, 0, 1'b1, 1'b1, 12'hFFE);
    check("perf_retired", retired_cnt, PERF ? 32'd3 : 32'd0);
    check("perf_cycle", cycle_cnt, PERF ? 32'd11 : 32'd0);

    // addi x2,x0,2047 aborted by reset while in WB
    instr = 32'h7FF00113;
    imem_ready = 1'b1;
    push(1, 0, 0, 3'b000, 0, 12'h000, 0);
    step();
    imem_ready = 1'b0;
    step();
    push(0, 0, 0, 3'b000, 1, 12'h7FF, 0);
    step();
    check("wb_regwrite_before_rst", RegWrite, 1);
    rst_n = 1'b0;
    #1;
    check("wb_rst_strobes", {RegWrite, PCWrite, IRWrite, ALUsrc}, 0);
    check("wb_rst_busy", busy, 0);
    check("wb_rst_retired", retired_cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_rst", {busy, imem_req}, 0);
    check("scoreboard_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
